// File: rtl/hd_transfer_controller.sv
// Block-transfer sequencer between the track/sector hard drive and main memory.
// Walks N consecutive sectors across track boundaries, one word per step.
module hd_transfer_controller #(
  parameter int DATA_WIDTH        = 32,
  parameter int TRACKS            = 2,
  parameter int SECTORS_PER_TRACK = 98,
  parameter int MEM_ADDR_WIDTH    = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      dir,
  input  logic [6:0]                track_base,
  input  logic [13:0]               sector_base,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_base,
  input  logic [13:0]               length,
  output logic [6:0]                track,
  output logic [13:0]               sector,
  output logic                      flag_write_hd,
  output logic [DATA_WIDTH-1:0]     data_write,
  input  logic [DATA_WIDTH-1:0]     hd_rdata,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_we,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD,
    S_SRD,
    S_SWR,
    S_FIN
  } state_t;

  localparam int unsigned CAPACITY = TRACKS * SECTORS_PER_TRACK;
  localparam int unsigned MEM_SPAN = 1 << MEM_ADDR_WIDTH;

  state_t      state;
  state_t      state_n;
  logic        dir_q;
  logic [13:0] len_q;
  logic [13:0] remaining;
  logic        reject_q;

  logic [31:0] lin_end;
  logic [31:0] mem_end;
  logic        reject;
  logic        last;
  logic        sector_wrap;
  logic        advance;

  // Start pointers already sit in track/sector/mem_addr while in CHECK
  assign lin_end = 32'(track) * 32'(SECTORS_PER_TRACK)
                 + 32'(sector) + 32'(len_q);
  assign mem_end = 32'(mem_addr) + 32'(len_q);

  assign reject = (len_q == 14'd0)
               || (32'(track) >= 32'(TRACKS))
               || (32'(sector) >= 32'(SECTORS_PER_TRACK))
               || (lin_end > CAPACITY)
               || (mem_end > MEM_SPAN);

  assign last        = (remaining == 14'd1);
  assign sector_wrap = (32'(sector) == 32'(SECTORS_PER_TRACK - 1));
  assign advance     = (state == S_LOAD) || (state == S_SWR);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_CHECK;
      S_CHECK: begin
        if (reject)     state_n = S_FIN;
        else if (dir_q) state_n = S_SRD;
        else            state_n = S_LOAD;
      end
      S_LOAD:  if (last) state_n = S_FIN;
      S_SRD:   state_n = S_SWR;
      S_SWR:   state_n = last ? S_FIN : S_SRD;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      dir_q     <= 1'b0;
      len_q     <= '0;
      remaining <= '0;
      reject_q  <= 1'b0;
      track     <= '0;
      sector    <= '0;
      mem_addr  <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        dir_q    <= dir;
        len_q    <= length;
        track    <= track_base;
        sector   <= sector_base;
        mem_addr <= mem_base;
        reject_q <= 1'b0;
      end
      if (state == S_CHECK) begin
        remaining <= len_q;
        reject_q  <= reject;
      end
      if (advance) begin
        remaining <= remaining - 14'd1;
        mem_addr  <= mem_addr + 1'b1;
        if (sector_wrap) begin
          sector <= '0;
          track  <= track + 7'd1;
        end else begin
          sector <= sector + 14'd1;
        end
      end
    end
  end

  assign busy          = (state != S_IDLE);
  assign done          = (state == S_FIN);
  assign error         = (state == S_FIN) && reject_q;
  assign mem_we        = (state == S_LOAD);
  assign flag_write_hd = (state == S_SWR);
  assign mem_wdata     = hd_rdata;
  assign data_write    = mem_rdata;

endmodule

// File: tb/tb_hd_transfer_controller.sv
// Directed bench for hd_transfer_controller with drive and memory models.
// Expected values are hand-computed per vector.
module tb_hd_transfer_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        dir;
  logic [6:0]  track_base;
  logic [13:0] sector_base;
  logic [9:0]  mem_base;
  logic [13:0] length;
  logic [6:0]  track;
  logic [13:0] sector;
  logic        flag_write_hd;
  logic [31:0] data_write;
  logic [31:0] hd_rdata;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        error;

  hd_transfer_controller dut (
    .clock(clock), .reset(reset), .start(start), .dir(dir),
    .track_base(track_base), .sector_base(sector_base),
    .mem_base(mem_base), .length(length),
    .track(track), .sector(sector),
    .flag_write_hd(flag_write_hd), .data_write(data_write),
    .hd_rdata(hd_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  logic [31:0] hd  [0:195];
  logic [31:0] mem [0:1023];
  logic        pl_hd;
  logic        pl_mem;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;
  int          hd_idx;

  always_comb begin
    hd_idx   = int'(track) * 98 + int'(sector);
    hd_rdata = (hd_idx < 196) ? hd[hd_idx] : 32'd0;
  end

  always @(posedge clock) begin
    if (flag_write_hd && hd_idx < 196) hd[hd_idx] <= data_write;
    else if (pl_hd) hd[int'(pl_addr)] <= pl_data;
  end

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pl_mem) mem[pl_addr] <= pl_data;
    mem_rdata <= mem[mem_addr];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic to_hd, input int a, input logic [31:0] d);
    @(negedge clock);
    pl_hd   = to_hd;
    pl_mem  = !to_hd;
    pl_addr = 10'(a);
    pl_data = d;
    @(posedge clock);
    #1;
    pl_hd  = 1'b0;
    pl_mem = 1'b0;
  endtask

  int done_at, err_at, we_cnt, fw_cnt, both_cnt, alt_bad;
  int we_first, we_last;
  int addr_log[$];

  task automatic run_cmd(input logic d, input logic [6:0] t,
                         input logic [13:0] s, input logic [9:0] m,
                         input logic [13:0] l);
    @(negedge clock);
    dir = d; track_base = t; sector_base = s;
    mem_base = m; length = l; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    done_at = 0; err_at = 0; we_cnt = 0; fw_cnt = 0;
    both_cnt = 0; alt_bad = 0; we_first = 0; we_last = 0;
    addr_log.delete();
    for (int off = 1; off <= 300 && done_at == 0; off++) begin
      @(negedge clock);
      if (mem_we && flag_write_hd) both_cnt++;
      if (mem_we) begin
        if (we_cnt == 0) we_first = off;
        we_last = off;
        we_cnt++;
        addr_log.push_back(int'(track) * 98 + int'(sector));
      end
      if (flag_write_hd) fw_cnt++;
      if (d && off >= 2 && !done && flag_write_hd != (off % 2 == 1))
        alt_bad++;
      if (done) begin
        done_at = off;
        err_at  = int'(error);
      end
    end
    if (done_at == 0) chk("timeout", 32'd0, 32'd1);
  endtask

  logic [6:0]  rj_t [4] = '{7'd0, 7'd2, 7'd1, 7'd0};
  logic [13:0] rj_s [4] = '{14'd0, 14'd0, 14'd97, 14'd0};
  logic [9:0]  rj_m [4] = '{10'd0, 10'd0, 10'd0, 10'd1020};
  logic [13:0] rj_l [4] = '{14'd0, 14'd1, 14'd2, 14'd8};

  initial begin
    int nd, nw, first_d, second_d;
    logic b5, b6;
    reset = 1'b1; start = 1'b0; dir = 1'b0;
    track_base = '0; sector_base = '0; mem_base = '0; length = '0;
    pl_hd = 1'b0; pl_mem = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_we", 32'({mem_we, flag_write_hd}), 32'd0);
    chk("rst_addr", {8'd0, track, sector, mem_addr}, 32'd0);

    // 1: load T1 S0..3 into mem[8..11]
    poke(1, 98, 1); poke(1, 99, 1); poke(1, 100, 0); poke(1, 101, 1);
    for (int i = 8; i < 12; i++) poke(0, i, 32'hDEAD);
    run_cmd(0, 1, 0, 8, 4);
    chk("ld_done_at", done_at, 6);
    chk("ld_err", err_at, 0);
    chk("ld_we_cnt", we_cnt, 4);
    chk("ld_we_run", we_last - we_first + 1, 4);
    chk("ld_fw", fw_cnt, 0);
    chk("ld_m8", mem[8], 1);
    chk("ld_m9", mem[9], 1);
    chk("ld_m10", mem[10], 0);
    chk("ld_m11", mem[11], 1);
    @(negedge clock);
    chk("ld_idle", 32'(busy), 32'd0);

    // 2: track wrap T0 S96 -> T1 S1
    poke(1, 96, 32'h11); poke(1, 97, 32'h22);
    poke(1, 98, 32'h33); poke(1, 99, 32'h44);
    run_cmd(0, 0, 96, 100, 4);
    chk("wr_done_at", done_at, 6);
    chk("wr_cnt", addr_log.size(), 4);
    if (addr_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("wr_addr", addr_log[i], 96 + i);
    chk("wr_m100", mem[100], 32'h11);
    chk("wr_m102", mem[102], 32'h33);
    chk("wr_m103", mem[103], 32'h44);

    // 3: store mem[20..22] to T1 S10..12
    poke(0, 20, 32'hA5A5A5A5); poke(0, 21, 1); poke(0, 22, 32'hFFFFFFFF);
    for (int i = 108; i < 111; i++) poke(1, i, 0);
    run_cmd(1, 1, 10, 20, 3);
    chk("st_done_at", done_at, 8);
    chk("st_err", err_at, 0);
    chk("st_fw_cnt", fw_cnt, 3);
    chk("st_we", we_cnt, 0);
    chk("st_alt", alt_bad, 0);
    chk("st_both", both_cnt, 0);
    chk("st_h108", hd[108], 32'hA5A5A5A5);
    chk("st_h109", hd[109], 1);
    chk("st_h110", hd[110], 32'hFFFFFFFF);

    // 4: rejects, then a just-fitting command at the last sector
    for (int i = 0; i < 4; i++) begin
      run_cmd(0, rj_t[i], rj_s[i], rj_m[i], rj_l[i]);
      chk("rj_done_at", done_at, 2);
      chk("rj_err", err_at, 1);
      chk("rj_writes", we_cnt + fw_cnt, 0);
    end
    poke(1, 195, 32'h5EC);
    run_cmd(0, 1, 97, 0, 1);
    chk("edge_done_at", done_at, 3);
    chk("edge_err", err_at, 0);
    chk("edge_m0", mem[0], 32'h5EC);

    // 5: reset during the second SWR of a 4-word store
    for (int i = 0; i < 4; i++) poke(0, 40 + i, 10 * (i + 1));
    for (int i = 0; i < 4; i++) poke(1, i, 0);
    @(negedge clock);
    dir = 1; track_base = 0; sector_base = 0;
    mem_base = 40; length = 4; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(negedge clock);
    chk("rs_in_swr", 32'(flag_write_hd), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_addr", {8'd0, track, sector, mem_addr}, 32'd0);
    nd = 0; nw = 0;
    repeat (5) begin
      @(negedge clock);
      nd += int'(done);
      nw += int'(flag_write_hd) + int'(mem_we);
    end
    chk("rs_quiet", nd + nw, 0);
    chk("rs_h0", hd[0], 10);
    chk("rs_h1", hd[1], 20);
    chk("rs_h2", hd[2], 0);
    chk("rs_h3", hd[3], 0);

    // 6: start held high across a whole command
    poke(1, 118, 32'h66); poke(1, 119, 32'h77);
    @(negedge clock);
    dir = 0; track_base = 1; sector_base = 20;
    mem_base = 200; length = 2; start = 1'b1;
    @(posedge clock);
    nd = 0; nw = 0; first_d = 0; second_d = 0; b5 = 1'b1; b6 = 1'b0;
    for (int off = 1; off <= 14; off++) begin
      @(negedge clock);
      if (done) begin
        nd++;
        if (first_d == 0) first_d = off;
        else second_d = off;
      end
      if (mem_we) nw++;
      if (off == 5) b5 = busy;
      if (off == 6) begin
        b6 = busy;
        start = 1'b0;
      end
    end
    chk("hs_first", first_d, 4);
    chk("hs_gap", 32'(b5), 32'd0);
    chk("hs_restart", 32'(b6), 32'd1);
    chk("hs_second", second_d, 9);
    chk("hs_ndone", nd, 2);
    chk("hs_nwe", nw, 4);
    chk("hs_m200", mem[200], 32'h66);
    chk("hs_m201", mem[201], 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
